// File: rtl/uart_rx_frame_if.sv
// Received-frame output stage of uart_rx_frame: data word, error flags and valid/ready handshake.
// The receiver drives through the master modport and the consumer attaches to slave.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver (5..9 data bits, none/even/odd parity, 1 or 2 stop bits) with a
// valid/ready output stage. Define UART_RX_MAJORITY_VOTE_EN for 3-sample majority bit decisions.
module uart_rx_frame #(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 12_000,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic            i_uart_clk,
  input  logic            i_reset_n,
  input  logic            i_uart_in,
  uart_rx_frame_if.master bus
);
  localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW              = $clog2(CLOCKS_PER_BAUD);
  localparam logic ODD_PARITY    = (PARITY_MODE == 2);

  generate
    if (CLOCKS_PER_BAUD < 8) begin : g_bad_baud
      $error("uart_rx_frame: CLOCK_FREQUENCY/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_rx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

  state_t               state_reg, state_next;
  logic                 sync_reg, rx_reg, rx_prev_reg;
  logic [1:0]           flush_reg;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [3:0]           idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 perr_reg, perr_next;
  logic                 zero_reg, zero_next;
  logic                 stop_reg, stop_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, perr_out_reg, ferr_out_reg, brk_out_reg, overrun_reg;
  logic                 in_frame, fall, sample_tick, bit_val;
  logic                 complete, done_ferr, done_brk, accept;

  // Edges are only trusted once the preset-1 synchroniser has been flushed with real line values,
  // so a line already low at reset release is not mistaken for a start bit.
  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_reg    <= 1'b1;
      rx_reg      <= 1'b1;
      rx_prev_reg <= 1'b1;
      flush_reg   <= 2'd0;
    end else begin
      sync_reg    <= i_uart_in;
      rx_reg      <= sync_reg;
      rx_prev_reg <= rx_reg;
      if (flush_reg != 2'd3) flush_reg <= flush_reg + 2'd1;
    end
  end

  assign in_frame = (state_reg == START) || (state_reg == DATA) ||
                    (state_reg == PARITY) || (state_reg == STOP);
  assign fall     = (flush_reg == 2'd3) && rx_prev_reg && !rx_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a_reg, vote_b_reg, vote_tick_reg;

  // Samples at counter 1 and 0 are held; the decision is taken one cycle later with the third.
  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vote_a_reg    <= 1'b1;
      vote_b_reg    <= 1'b1;
      vote_tick_reg <= 1'b0;
    end else begin
      if (cnt_reg == CW'(1)) vote_a_reg <= rx_reg;
      if (cnt_reg == '0)     vote_b_reg <= rx_reg;
      vote_tick_reg <= in_frame && (cnt_reg == '0);
    end
  end

  assign sample_tick = vote_tick_reg;
  assign bit_val     = (vote_a_reg & vote_b_reg) | (vote_a_reg & rx_reg) | (vote_b_reg & rx_reg);
`else
  assign sample_tick = in_frame && (cnt_reg == '0);
  assign bit_val     = rx_reg;
`endif

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      stop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      perr_reg  <= perr_next;
      zero_reg  <= zero_next;
      stop_reg  <= stop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    perr_next  = perr_reg;
    zero_next  = zero_reg;
    stop_next  = stop_reg;
    complete   = 1'b0;
    done_ferr  = 1'b0;
    done_brk   = 1'b0;
    if (in_frame) cnt_next = (cnt_reg == '0) ? CW'(CLOCKS_PER_BAUD - 1) : cnt_reg - CW'(1);
    case (state_reg)
      IDLE: if (fall) begin
        state_next = START;
        cnt_next   = CW'(CLOCKS_PER_BAUD / 2 - 1);
      end
      START: if (sample_tick) begin
        if (bit_val) begin
          state_next = IDLE;
        end else begin
          state_next = DATA;
          idx_next   = '0;
          par_next   = 1'b0;
          perr_next  = 1'b0;
          zero_next  = 1'b1;
        end
      end
      DATA: if (sample_tick) begin
        // LSB arrives first, so after DATA_BITS shifts bit k sits at position k.
        shift_next = {bit_val, shift_reg[DATA_BITS-1:1]};
        par_next   = par_reg ^ bit_val;
        if (bit_val) zero_next = 1'b0;
        stop_next  = 1'b0;
        if (idx_reg == 4'(DATA_BITS - 1)) state_next = (PARITY_MODE != 0) ? PARITY : STOP;
        else idx_next = idx_reg + 4'd1;
      end
      PARITY: if (sample_tick) begin
        perr_next  = ((par_reg ^ bit_val) != ODD_PARITY);
        if (bit_val) zero_next = 1'b0;
        state_next = STOP;
      end
      STOP: if (sample_tick) begin
        if (!bit_val) begin
          complete   = 1'b1;
          done_ferr  = 1'b1;
          done_brk   = zero_reg && (stop_reg == 1'b0);
          state_next = RECOVER;
        end else if (stop_reg == 1'(STOP_BITS - 1)) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else begin
          stop_next = stop_reg + 1'b1;
        end
      end
      RECOVER: if (rx_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = valid_reg && bus.i_ready;

  // A completing frame may replace one that is being accepted in the same cycle.
  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      brk_out_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (complete && (!valid_reg || accept)) begin
        data_reg     <= shift_reg;
        valid_reg    <= 1'b1;
        perr_out_reg <= perr_reg;
        ferr_out_reg <= done_ferr;
        brk_out_reg  <= done_brk;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
      if (complete && valid_reg && !accept) overrun_reg <= 1'b1;
      else if (accept)                      overrun_reg <= 1'b0;
    end
  end

  assign bus.o_data       = data_reg;
  assign bus.o_valid      = valid_reg;
  assign bus.o_parity_err = perr_out_reg;
  assign bus.o_frame_err  = ferr_out_reg;
  assign bus.o_break      = brk_out_reg;
  assign bus.o_overrun    = overrun_reg;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and a 7-bit even-parity 2-stop instance, driven with
// directed and random frames and checked against a frame-level model. Honours UART_RX_MAJORITY_VOTE_EN.
module tb_uart_rx_frame;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT = 99;
`else
  localparam int LAT = 98;
`endif

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    int         cyc;
  } frame_t;

  logic   clk    = 1'b0;
  logic   rst_n  = 1'b0;
  logic   line_a = 1'b1;
  logic   line_b = 1'b1;
  int     cyc    = 0;
  int     checks = 0;
  int     passes = 0;
  frame_t cap_a[$];
  frame_t cap_b[$];
  frame_t mon_a, mon_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_frame_if #(.DATA_BITS(7)) bus_b ();

  uart_rx_frame #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_uart_clk(clk), .i_reset_n(rst_n), .i_uart_in(line_a), .bus(bus_a));

  uart_rx_frame #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
                  .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .i_uart_clk(clk), .i_reset_n(rst_n), .i_uart_in(line_b), .bus(bus_b));

  // Every accepted transfer is recorded with the cycle it was seen on.
  always @(negedge clk) begin
    if (bus_a.o_valid && bus_a.i_ready) begin
      mon_a.data = 9'(bus_a.o_data); mon_a.pe = bus_a.o_parity_err;
      mon_a.fe = bus_a.o_frame_err; mon_a.brk = bus_a.o_break; mon_a.cyc = cyc;
      cap_a.push_back(mon_a);
    end
    if (bus_b.o_valid && bus_b.i_ready) begin
      mon_b.data = 9'(bus_b.o_data); mon_b.pe = bus_b.o_parity_err;
      mon_b.fe = bus_b.o_frame_err; mon_b.brk = bus_b.o_break; mon_b.cyc = cyc;
      cap_b.push_back(mon_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [8:0] data, input int nbits, input int pmode,
                                   input logic pbit, input logic s1, input logic s2, input int nstop);
    frame_t f;
    logic [8:0] m;
    m      = data & 9'((1 << nbits) - 1);
    f.data = m;
    f.fe   = !s1 || (nstop == 2 && !s2);
    f.brk  = (m == 9'd0) && (pmode == 0 || !pbit) && !s1;
    f.pe   = (pmode == 0) ? 1'b0 : (((($countones(m) + int'(pbit)) % 2) != (pmode == 2 ? 1 : 0)));
    f.cyc  = -1;
    return f;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) line_b = v; else line_a = v;
  endtask

  // Start, data LSB first, optional parity, stops; then one idle bit time.
  task automatic send(input bit sel, input logic [8:0] data, input int nbits, input bit has_par,
                      input logic pbit, input logic s1, input logic s2, input int nstop);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin bits[n] = data[i]; n++; end
    if (has_par) begin bits[n] = pbit; n++; end
    bits[n] = s1; n++;
    if (nstop == 2) begin bits[n] = s2; n++; end
    for (int i = 0; i < n; i++) begin drive(sel, bits[i]); tick(CPB); end
    drive(sel, 1'b1);
    tick(CPB);
  endtask

  task automatic expect_frame(input bit sel, input string tag, input frame_t e, output frame_t c);
    int n;
    n = sel ? cap_b.size() : cap_a.size();
    c = e;
    chk({tag, ".count"}, n, 1);
    if (n > 0) begin
      if (sel) c = cap_b.pop_front(); else c = cap_a.pop_front();
      chk({tag, ".data"}, c.data, e.data);
      chk({tag, ".parity_err"}, c.pe, e.pe);
      chk({tag, ".frame_err"}, c.fe, e.fe);
      chk({tag, ".break"}, c.brk, e.brk);
    end
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic expect_none(input bit sel, input string tag);
    chk({tag, ".count"}, sel ? cap_b.size() : cap_a.size(), 0);
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".a_valid"}, bus_a.o_valid, 0);
    chk({tag, ".a_data"}, bus_a.o_data, 0);
    chk({tag, ".a_flags"}, {bus_a.o_parity_err, bus_a.o_frame_err, bus_a.o_break, bus_a.o_overrun}, 0);
    chk({tag, ".b_valid"}, bus_b.o_valid, 0);
    chk({tag, ".b_data"}, bus_b.o_data, 0);
    chk({tag, ".b_flags"}, {bus_b.o_parity_err, bus_b.o_frame_err, bus_b.o_break, bus_b.o_overrun}, 0);
  endtask

  initial begin
    frame_t c;
    int start;
    logic [8:0] d;
    logic p, s1, s2;

    bus_a.i_ready = 1'b1;
    bus_b.i_ready = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(5);
    check_idle_outputs("post_reset");

    // 8N1 0xA5 with exact o_valid latency from the line edge.
    start = cyc;
    send(0, 9'hA5, 8, 0, 0, 1, 1, 1);
    expect_frame(0, "a5", model(9'hA5, 8, 0, 0, 1, 1, 1), c);
    chk("a5.latency", c.cyc - start, LAT);

    // 7E2 0x55 (four ones): parity bit 1 is wrong, 0 is right.
    send(1, 9'h55, 7, 1, 1, 1, 1, 2);
    expect_frame(1, "par_bad", model(9'h55, 7, 1, 1, 1, 1, 2), c);
    send(1, 9'h55, 7, 1, 0, 1, 1, 2);
    expect_frame(1, "par_ok", model(9'h55, 7, 1, 0, 1, 1, 2), c);

    // Short low glitch on an idle line, then a normal frame proves the receiver is idle again.
    line_a = 1'b0; tick(3); line_a = 1'b1; tick(3 * CPB);
    expect_none(0, "glitch");
    send(0, 9'h3A, 8, 0, 0, 1, 1, 1);
    expect_frame(0, "after_glitch", model(9'h3A, 8, 0, 0, 1, 1, 1), c);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle low exactly at mid-bit of data bit 3 of 0xFF is outvoted.
    line_a = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line_a = 1'b1;
      if (i == 3) begin tick(5); line_a = 1'b0; tick(1); line_a = 1'b1; tick(4); end
      else tick(CPB);
    end
    line_a = 1'b1; tick(2 * CPB);
    expect_frame(0, "vote", model(9'hFF, 8, 0, 0, 1, 1, 1), c);
`endif

    // Line held low for 12 bit times: one break frame, nothing more until a new edge.
    line_a = 1'b0; tick(12 * CPB); line_a = 1'b1; tick(3 * CPB);
    expect_frame(0, "break", model(9'h00, 8, 0, 0, 0, 1, 1), c);
    tick(5 * CPB);
    expect_none(0, "break_tail");

    // Backpressure: three frames arrive, only the first is held.
    bus_a.i_ready = 1'b0;
    send(0, 9'h11, 8, 0, 0, 1, 1, 1);
    send(0, 9'h22, 8, 0, 0, 1, 1, 1);
    send(0, 9'h33, 8, 0, 0, 1, 1, 1);
    @(negedge clk);
    chk("ovr.valid", bus_a.o_valid, 1);
    chk("ovr.data", bus_a.o_data, 8'h11);
    chk("ovr.overrun", bus_a.o_overrun, 1);
    tick(1);
    bus_a.i_ready = 1'b1;
    tick(1);
    bus_a.i_ready = 1'b0;
    @(negedge clk);
    chk("ovr.overrun_clr", bus_a.o_overrun, 0);
    chk("ovr.valid_clr", bus_a.o_valid, 0);
    expect_frame(0, "ovr_xfer", model(9'h11, 8, 0, 0, 1, 1, 1), c);

    // Reset during data bit 4 (line low there), holding a frame in the output stage.
    send(0, 9'h5A, 8, 0, 0, 1, 1, 1);
    fork
      send(0, 9'h0F, 8, 0, 0, 1, 1, 1);
      begin
        tick(53);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        tick(3);
        rst_n = 1'b1;
      end
    join
    bus_a.i_ready = 1'b1;
    tick(2 * CPB);
    expect_none(0, "reset_abort");
    send(0, 9'h3C, 8, 0, 0, 1, 1, 1);
    expect_frame(0, "after_reset", model(9'h3C, 8, 0, 0, 1, 1, 1), c);

    // Random traffic against the frame model.
    for (int i = 0; i < 10; i++) begin
      d  = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 255));
      s1 = ($urandom_range(0, 3) != 0);
      send(0, d, 8, 0, 0, s1, 1, 1);
      expect_frame(0, "rnd_a", model(d, 8, 0, 0, s1, 1, 1), c);
    end
    for (int i = 0; i < 12; i++) begin
      d  = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 127));
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send(1, d, 7, 1, p, s1, s2, 2);
      expect_frame(1, "rnd_b", model(d, 7, 1, p, s1, s2, 2), c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that supersedes the fixed 8N1 receiver. It supports 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. It reports parity, framing, overrun and break conditions, and delivers each frame through a valid/ready output stage so the consumer can apply backpressure. It sits between the board RX pin and the command/packet decoders.

## Interface
Parameters:
- CLOCK_FREQUENCY, 1_000_000, i_uart_clk frequency in Hz
- BAUD_RATE, 12_000, line bit rate; CLOCKS_PER_BAUD = CLOCK_FREQUENCY/BAUD_RATE (integer divide), must be ≥ 8, elaboration error otherwise
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2

Ports:
- i_uart_clk  input  1  sole clock
- i_reset_n  input  1  asynchronous active-low reset
- i_uart_in  input  1  raw RX line, asynchronous, idle high
- o_data  output  DATA_BITS  received data word
- o_valid  output  1  o_data and flags hold a frame
- i_ready  input  1  consumer accepts the frame when o_valid & i_ready at a clock edge
- o_parity_err  output  1  parity mismatch for the presented frame; always 0 when PARITY_MODE = 0
- o_frame_err  output  1  a stop bit was sampled low for the presented frame
- o_break  output  1  presented frame had all data, parity and first-stop samples low
- o_overrun  output  1  sticky; set when a completed frame was dropped

## Operation
- i_uart_in passes through a 2-FF synchroniser; all logic uses the synchronised value `rx`.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
- IDLE, on `rx` 1→0 edge: go to START and load the baud counter with CLOCKS_PER_BAUD/2 − 1.
- Sampling: a bit is sampled when the baud counter reaches 0; the counter then reloads CLOCKS_PER_BAUD − 1.
- START sample = 1 (glitch): return to IDLE with no output and no flags.
- START sample = 0: go to DATA, bit index = 0.
- DATA: each sample is written to shift position [index]. After DATA_BITS samples, go to PARITY if PARITY_MODE ≠ 0, else to STOP.
- PARITY: for even mode the error is XOR(data, sample) ≠ 0; for odd mode it is XOR(data, sample) ≠ 1.
- STOP: STOP_BITS samples; frame error if any stop sample is 0.
- Break: all data samples, the parity sample and the first stop sample are 0. This sets both break and frame error.
- Frame completion happens on the final stop sample, or immediately on the first low stop sample.
  - If the output stage is empty, or being accepted this same cycle, load o_data and the flags; o_valid = 1 next cycle.
  - Otherwise drop the new frame, set o_overrun, and leave the held frame unchanged.
- After a frame error, go to RECOVER. RECOVER waits for `rx` = 1, then goes to IDLE; no edge is detected while in RECOVER.
- After a good frame, go to IDLE directly.
- Clearing o_overrun:
  - It clears on the cycle after an o_valid & i_ready transfer, unless a drop occurs in that same cycle; a drop wins.
- A falling edge that arrives while not in IDLE is ignored.

## Timing
- Reset (asynchronous, i_reset_n = 0):
  - FSM goes to IDLE and the synchronisers are preset to 1.
  - o_data = 0, o_valid = 0, o_parity_err = 0, o_frame_err = 0, o_break = 0, o_overrun = 0.
- Reset mid-frame aborts the frame with no output. After release, a line that is already low is not treated as a start bit until a fresh 1→0 edge.
- Latency: i_uart_in change → `rx` is 2 cycles. Start edge seen at cycle E → first sample at E + CLOCKS_PER_BAUD/2. Bit k is sampled k·CLOCKS_PER_BAUD later.
- o_valid rises exactly 1 cycle after the completing sample.
- o_valid stays high until the transfer; o_data and the error flags are stable while o_valid = 1.
- o_valid & i_ready with no same-cycle completion: o_valid = 0 next cycle. With a same-cycle completion: o_valid stays 1 and the new frame is presented (back-to-back).

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: each bit value is the majority of three `rx` samples taken at counter values 1, 0 and CLOCKS_PER_BAUD − 1 (mid − 1, mid, mid + 1). The START glitch check uses the same vote. The completing sample is the third one, so all completion timing shifts +1 cycle.
- Not defined: single sample at counter = 0; no extra registers.

## Test plan
- 1 MHz clock, 100 kbaud, 8N1, byte 0xA5, i_ready = 1 → o_data = 0xA5, o_valid pulses 1 cycle, all flags 0. o_valid rises 2 + 5 + 9·10 + 1 = 98 cycles after the i_uart_in falling edge (99 with majority vote).
- PARITY_MODE = 1, DATA_BITS = 7, byte 0x55 sent with parity bit 1 → o_parity_err = 1. Sent with parity bit 0 → o_parity_err = 0.
- 3-cycle low glitch on an idle line → no o_valid, FSM back in IDLE. With majority vote, a 1-cycle glitch exactly at mid-bit of data bit 3 of 0xFF → o_data = 0xFF.
- Line held low for 12 bit times, then high → o_break = 1, o_frame_err = 1, o_data = 0x00. No second frame is reported until a new falling edge after the high.
- i_ready = 0 while three bytes 0x11, 0x22, 0x33 arrive → o_data stays 0x11, o_overrun = 1. After one transfer, o_overrun = 0 next cycle.
- Assert i_reset_n = 0 during data bit 4 → all outputs 0 immediately. After release, a full frame 0x3C is received correctly.
